// File: rtl/db_thresh_gen_pkg.sv
// Shared constants and the stage-1 record for the deblocking threshold generator.
package db_thresh_gen_pkg;

  localparam int unsigned QP_MAX        = 51;
  localparam int unsigned ALPHA_IDX_MIN = 16;
  localparam int unsigned ALPHA_W       = 8;
  localparam int unsigned BETA_W        = 5;
  localparam int unsigned TC_W          = 5;
  localparam int unsigned IDX_W         = 6;

  localparam logic [2:0] BS_STRONG = 3'd4;

  typedef struct packed {
    logic [IDX_W-1:0] idx_a;
    logic [IDX_W-1:0] idx_b;
    logic [2:0]       bs;
    logic             chroma;
  } s1_t;

endpackage

// File: rtl/db_thresh_gen_rom.sv
// Combinational alpha/beta/tc0 tables indexed by clipped indexA/indexB and bS.
module db_thresh_gen_rom
  import db_thresh_gen_pkg::*;
(
  input  logic [IDX_W-1:0]   idx_a_i,
  input  logic [IDX_W-1:0]   idx_b_i,
  input  logic [2:0]         bs_i,
  output logic [ALPHA_W-1:0] alpha_o,
  output logic [BETA_W-1:0]  beta_o,
  output logic [TC_W-1:0]    tc0_o
);

  // Packed {bS3, bS2, bS1} columns of the tc0 table.
  logic [3*TC_W-1:0] tc_row;

  always_comb begin
    alpha_o = '0;
    case (idx_a_i)
      6'd16, 6'd17: alpha_o = 8'd4;
      6'd18: alpha_o = 8'd5;     6'd19: alpha_o = 8'd6;     6'd20: alpha_o = 8'd7;
      6'd21: alpha_o = 8'd8;     6'd22: alpha_o = 8'd9;     6'd23: alpha_o = 8'd10;
      6'd24: alpha_o = 8'd12;    6'd25: alpha_o = 8'd13;    6'd26: alpha_o = 8'd15;
      6'd27: alpha_o = 8'd17;    6'd28: alpha_o = 8'd20;    6'd29: alpha_o = 8'd22;
      6'd30: alpha_o = 8'd25;    6'd31: alpha_o = 8'd28;    6'd32: alpha_o = 8'd32;
      6'd33: alpha_o = 8'd36;    6'd34: alpha_o = 8'd40;    6'd35: alpha_o = 8'd45;
      6'd36: alpha_o = 8'd50;    6'd37: alpha_o = 8'd56;    6'd38: alpha_o = 8'd63;
      6'd39: alpha_o = 8'd71;    6'd40: alpha_o = 8'd80;    6'd41: alpha_o = 8'd90;
      6'd42: alpha_o = 8'd101;   6'd43: alpha_o = 8'd113;   6'd44: alpha_o = 8'd127;
      6'd45: alpha_o = 8'd144;   6'd46: alpha_o = 8'd162;   6'd47: alpha_o = 8'd182;
      6'd48: alpha_o = 8'd203;   6'd49: alpha_o = 8'd226;
      6'd50, 6'd51: alpha_o = 8'd255;
      default: alpha_o = '0;
    endcase
  end

  always_comb begin
    beta_o = '0;
    case (idx_b_i)
      6'd16, 6'd17, 6'd18:        beta_o = 5'd2;
      6'd19, 6'd20, 6'd21, 6'd22: beta_o = 5'd3;
      6'd23, 6'd24, 6'd25:        beta_o = 5'd4;
      6'd26, 6'd27: beta_o = 5'd6;   6'd28, 6'd29: beta_o = 5'd7;
      6'd30, 6'd31: beta_o = 5'd8;   6'd32, 6'd33: beta_o = 5'd9;
      6'd34, 6'd35: beta_o = 5'd10;  6'd36, 6'd37: beta_o = 5'd11;
      6'd38, 6'd39: beta_o = 5'd12;  6'd40, 6'd41: beta_o = 5'd13;
      6'd42, 6'd43: beta_o = 5'd14;  6'd44, 6'd45: beta_o = 5'd15;
      6'd46, 6'd47: beta_o = 5'd16;  6'd48, 6'd49: beta_o = 5'd17;
      6'd50, 6'd51: beta_o = 5'd18;
      default: beta_o = '0;
    endcase
  end

  always_comb begin
    tc_row = '0;
    case (idx_a_i)
      6'd17, 6'd18, 6'd19, 6'd20: tc_row = {5'd1, 5'd0, 5'd0};
      6'd21, 6'd22:               tc_row = {5'd1, 5'd1, 5'd0};
      6'd23, 6'd24, 6'd25, 6'd26: tc_row = {5'd1, 5'd1, 5'd1};
      6'd27, 6'd28, 6'd29, 6'd30: tc_row = {5'd2, 5'd1, 5'd1};
      6'd31, 6'd32: tc_row = {5'd3, 5'd2, 5'd1};    6'd33: tc_row = {5'd3, 5'd2, 5'd2};
      6'd34: tc_row = {5'd4, 5'd2, 5'd2};           6'd35: tc_row = {5'd4, 5'd3, 5'd2};
      6'd36: tc_row = {5'd4, 5'd3, 5'd2};           6'd37: tc_row = {5'd5, 5'd3, 5'd3};
      6'd38: tc_row = {5'd6, 5'd4, 5'd3};           6'd39: tc_row = {5'd6, 5'd4, 5'd3};
      6'd40: tc_row = {5'd7, 5'd5, 5'd4};           6'd41: tc_row = {5'd8, 5'd5, 5'd4};
      6'd42: tc_row = {5'd9, 5'd6, 5'd4};           6'd43: tc_row = {5'd10, 5'd7, 5'd5};
      6'd44: tc_row = {5'd11, 5'd8, 5'd6};          6'd45: tc_row = {5'd13, 5'd8, 5'd6};
      6'd46: tc_row = {5'd14, 5'd10, 5'd7};         6'd47: tc_row = {5'd16, 5'd11, 5'd8};
      6'd48: tc_row = {5'd18, 5'd12, 5'd9};         6'd49: tc_row = {5'd20, 5'd13, 5'd10};
      6'd50: tc_row = {5'd23, 5'd15, 5'd11};        6'd51: tc_row = {5'd25, 5'd17, 5'd13};
      default: tc_row = '0;
    endcase
  end

  always_comb begin
    tc0_o = '0;
    case (bs_i)
      3'd1:    tc0_o = tc_row[TC_W-1:0];
      3'd2:    tc0_o = tc_row[2*TC_W-1:TC_W];
      3'd3:    tc0_o = tc_row[3*TC_W-1:2*TC_W];
      default: tc0_o = '0;
    endcase
  end

endmodule

// File: rtl/db_thresh_gen.sv
// Two-stage valid/ready pipeline: index computation with clipping, then registered table lookup.
module db_thresh_gen
  import db_thresh_gen_pkg::*;
#(
  parameter int unsigned QP_W  = 6,
  parameter int unsigned OFS_W = 5,
  parameter int unsigned BS_W  = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [QP_W-1:0]  qp_p_i,
  input  logic [QP_W-1:0]  qp_q_i,
  input  logic [OFS_W-1:0] alpha_ofs_i,
  input  logic [OFS_W-1:0] beta_ofs_i,
  input  logic [BS_W-1:0]  bs_i,
  input  logic             chroma_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [7:0]       alpha_o,
  output logic [4:0]       beta_o,
  output logic [4:0]       tc0_o,
  output logic [4:0]       tc_c_o,
  output logic             strong_o,
  output logic             filt_en_o,
  output logic             chroma_o
);

  localparam logic signed [QP_W+1:0] QpMaxS = $signed((QP_W+2)'(QP_MAX));

  function automatic logic [IDX_W-1:0] clip_idx(input logic signed [QP_W+1:0] v);
    if (v[QP_W+1]) return '0;
    if (v > QpMaxS) return IDX_W'(QP_MAX);
    return v[IDX_W-1:0];
  endfunction

  logic [QP_W:0]          qp_sum;
  logic [QP_W-1:0]        qp_avg;
  logic signed [QP_W+1:0] sum_a, sum_b;
  s1_t                    s1_d, s1_q;
  logic                   s1_valid_q;
  logic                   s1_load, s2_load;

  logic [ALPHA_W-1:0] alpha_rom;
  logic [BETA_W-1:0]  beta_rom;
  logic [TC_W-1:0]    tc0_rom;
  logic [TC_W-1:0]    tc_c_d;
  logic               strong_d, filt_en_d;

  assign qp_sum = {1'b0, qp_p_i} + {1'b0, qp_q_i} + {{QP_W{1'b0}}, 1'b1};
  assign qp_avg = qp_sum[QP_W:1];
  assign sum_a  = $signed({2'b00, qp_avg})
                + $signed({{(QP_W+2-OFS_W){alpha_ofs_i[OFS_W-1]}}, alpha_ofs_i});
  assign sum_b  = $signed({2'b00, qp_avg})
                + $signed({{(QP_W+2-OFS_W){beta_ofs_i[OFS_W-1]}}, beta_ofs_i});

  always_comb begin
    s1_d.idx_a  = clip_idx(sum_a);
    s1_d.idx_b  = clip_idx(sum_b);
    // Illegal bS 5..7 behave as a strong edge.
    s1_d.bs     = (bs_i > BS_W'(4)) ? BS_STRONG : bs_i[2:0];
    s1_d.chroma = chroma_i;
  end

  assign s2_load = !valid_o | ready_i;
  assign s1_load = !s1_valid_q | s2_load;
  assign ready_o = s1_load;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_q       <= '0;
    end else if (s1_load) begin
      s1_valid_q <= valid_i;
      if (valid_i) s1_q <= s1_d;
    end
  end

  db_thresh_gen_rom u_rom (
    .idx_a_i (s1_q.idx_a),
    .idx_b_i (s1_q.idx_b),
    .bs_i    (s1_q.bs),
    .alpha_o (alpha_rom),
    .beta_o  (beta_rom),
    .tc0_o   (tc0_rom)
  );

  always_comb begin
    tc_c_d    = (s1_q.bs != 3'd0 && s1_q.bs != BS_STRONG) ? tc0_rom + TC_W'(1) : '0;
    strong_d  = (s1_q.bs == BS_STRONG);
    filt_en_d = (s1_q.bs != 3'd0) && (s1_q.idx_a >= IDX_W'(ALPHA_IDX_MIN));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_o   <= 1'b0;
      alpha_o   <= '0;
      beta_o    <= '0;
      tc0_o     <= '0;
      tc_c_o    <= '0;
      strong_o  <= 1'b0;
      filt_en_o <= 1'b0;
      chroma_o  <= 1'b0;
    end else if (s2_load) begin
      valid_o <= s1_valid_q;
      if (s1_valid_q) begin
        alpha_o   <= alpha_rom;
        beta_o    <= beta_rom;
        tc0_o     <= tc0_rom;
        tc_c_o    <= tc_c_d;
        strong_o  <= strong_d;
        filt_en_o <= filt_en_d;
        chroma_o  <= s1_q.chroma;
      end
    end
  end

endmodule

// File: tb/tb_db_thresh_gen.sv
// Directed self-checking bench for db_thresh_gen with immediate assertions.
module tb_db_thresh_gen;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       valid_i, ready_o, valid_o, ready_i, chroma_i;
  logic [5:0] qp_p_i, qp_q_i;
  logic [4:0] alpha_ofs_i, beta_ofs_i;
  logic [2:0] bs_i;
  logic [7:0] alpha_o;
  logic [4:0] beta_o, tc0_o, tc_c_o;
  logic       strong_o, filt_en_o, chroma_o;

  int n_cmp = 0;
  int n_err = 0;

  db_thresh_gen dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .valid_i     (valid_i),
    .ready_o     (ready_o),
    .qp_p_i      (qp_p_i),
    .qp_q_i      (qp_q_i),
    .alpha_ofs_i (alpha_ofs_i),
    .beta_ofs_i  (beta_ofs_i),
    .bs_i        (bs_i),
    .chroma_i    (chroma_i),
    .valid_o     (valid_o),
    .ready_i     (ready_i),
    .alpha_o     (alpha_o),
    .beta_o      (beta_o),
    .tc0_o       (tc0_o),
    .tc_c_o      (tc_c_o),
    .strong_o    (strong_o),
    .filt_en_o   (filt_en_o),
    .chroma_o    (chroma_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag, input int ea, input int eb, input int et,
                           input int ec, input int es, input int ef, input int ech);
    check({tag, "_alpha"},  32'(alpha_o),   32'(ea));
    check({tag, "_beta"},   32'(beta_o),    32'(eb));
    check({tag, "_tc0"},    32'(tc0_o),     32'(et));
    check({tag, "_tc_c"},   32'(tc_c_o),    32'(ec));
    check({tag, "_strong"}, 32'(strong_o),  32'(es));
    check({tag, "_filt"},   32'(filt_en_o), 32'(ef));
    check({tag, "_chroma"}, 32'(chroma_o),  32'(ech));
  endtask

  task automatic drive(input int qpp, input int qpq, input int ao, input int bo,
                       input int bs, input int ch);
    qp_p_i      = 6'(qpp);
    qp_q_i      = 6'(qpq);
    alpha_ofs_i = 5'(ao);
    beta_ofs_i  = 5'(bo);
    bs_i        = 3'(bs);
    chroma_i    = ch[0];
  endtask

  // One request with ready_i high: accepted, invisible after one edge, valid after two.
  task automatic single(input string tag, input int qpp, input int qpq, input int ao,
                        input int bo, input int bs, input int ch, input int ea, input int eb,
                        input int et, input int ec, input int es, input int ef);
    @(negedge clk);
    drive(qpp, qpq, ao, bo, bs, ch);
    valid_i = 1'b1;
    #1 check({tag, "_ready"}, 32'(ready_o), 32'd1);
    @(negedge clk);
    valid_i = 1'b0;
    check({tag, "_lat1"}, 32'(valid_o), 32'd0);
    @(negedge clk);
    check({tag, "_valid"}, 32'(valid_o), 32'd1);
    check_out(tag, ea, eb, et, ec, es, ef, ch);
  endtask

  int qps[5]        = '{20, 25, 30, 35, 40};
  int stream_a[5]   = '{7, 13, 25, 45, 80};
  int exp_rdy[12]   = '{1, 1, 1, 0, 0, 0, 0, 1, 1, 1, 1, 1};
  int exp_vld[12]   = '{0, 0, 1, 1, 1, 1, 1, 1, 1, 1, 1, 0};
  int exp_idx[12]   = '{-1, -1, 0, 1, 1, 1, 1, 1, 2, 3, 4, -1};
  int sent;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n   = 1'b0;
    valid_i = 1'b0;
    ready_i = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    #12;
    check("rst_valid", 32'(valid_o), 32'd0);
    check("rst_ready", 32'(ready_o), 32'd1);
    check_out("rst", 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;

    single("t_qp30",      30, 30,   0,   0, 2, 0,  25,  8,  1,  2, 0, 1);
    single("t_qp51_ofs",  51, 50,  12, -12, 4, 0, 255, 12,  0,  0, 1, 1);
    single("t_qp10",      10, 10,   0,   0, 1, 0,   0,  0,  0,  1, 0, 0);
    single("t_qp0_clip",   0,  0, -12,   0, 1, 0,   0,  0,  0,  1, 0, 0);
    single("t_bs0",       40, 40,   0,   0, 0, 0,  80, 13,  0,  0, 0, 0);
    single("t_chroma",    30, 30,   0,   0, 3, 1,  25,  8,  2,  3, 0, 1);
    single("t_bs7",       30, 30,   0,   0, 7, 0,  25,  8,  0,  0, 1, 1);
    single("t_qp63",      63, 63,   0,   0, 1, 0, 255, 18, 13, 14, 0, 1);
    single("t_idx16",     16, 16,   0,   0, 1, 0,   4,  2,  0,  1, 0, 1);
    single("t_idx17",     17, 17,   0,   0, 3, 0,   4,  2,  1,  2, 0, 1);

    // Five back-to-back requests with ready_i low for cycles 3..6.
    sent = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      ready_i = (c < 3 || c > 6);
      if (sent < 5) begin
        drive(qps[sent], qps[sent], 0, 0, 2, 0);
        valid_i = 1'b1;
      end else begin
        valid_i = 1'b0;
      end
      #1;
      check($sformatf("stream_ready_c%0d", c), 32'(ready_o), 32'(exp_rdy[c]));
      check($sformatf("stream_valid_c%0d", c), 32'(valid_o), 32'(exp_vld[c]));
      if (exp_idx[c] >= 0)
        check($sformatf("stream_alpha_c%0d", c), 32'(alpha_o), 32'(stream_a[exp_idx[c]]));
      if (valid_i && ready_o) sent++;
    end
    valid_i = 1'b0;
    ready_i = 1'b1;
    check("stream_sent", 32'(sent), 32'd5);

    // Reset with two requests in flight.
    @(negedge clk);
    drive(30, 30, 0, 0, 2, 0);
    valid_i = 1'b1;
    @(negedge clk);
    @(negedge clk);
    valid_i = 1'b0;
    check("mid_pre_valid", 32'(valid_o), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(valid_o), 32'd0);
    check("mid_rst_alpha", 32'(alpha_o), 32'd0);
    check("mid_rst_filt",  32'(filt_en_o), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 check("mid_rel_ready", 32'(ready_o), 32'd1);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check($sformatf("mid_stale_c%0d", c), 32'(valid_o), 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/db_thresh_gen.md
Name: db_thresh_gen

Overview:
- Pipelined deblocking-threshold generator for the H.264 loop filter.
- Per edge request, takes (qp_p, qp_q, slice offsets, bS, luma/chroma) and computes indexA/indexB with clipping.
- Returns registered alpha, beta, tc0 and tc_c, plus a filter-enable decision.
- Sits between the bS calculator and the edge filter datapath; replaces ad-hoc combinational table lookups with a valid/ready stage that holds under downstream stall.

Parameters:
- QP_W, 6, width of qp inputs (legal values 0..51).
- OFS_W, 5, width of signed offsets (legal range -12..+12, i.e. offset_div2*2).
- BS_W, 3, width of boundary strength (legal values 0..4).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- valid_i  in  1  request valid
- ready_o  out  1  request accepted when valid_i & ready_o
- qp_p_i  in  QP_W  QP of the P block (chroma QP when chroma_i=1)
- qp_q_i  in  QP_W  QP of the Q block
- alpha_ofs_i  in  OFS_W  signed FilterOffsetA
- beta_ofs_i  in  OFS_W  signed FilterOffsetB
- bs_i  in  BS_W  boundary strength
- chroma_i  in  1  1 = chroma edge
- valid_o  out  1  result valid
- ready_i  in  1  downstream accepts when valid_o & ready_i
- alpha_o  out  8  alpha(indexA)
- beta_o  out  5  beta(indexB)
- tc0_o  out  5  tc0(indexA, bS); 0 when bS is 0 or 4
- tc_c_o  out  5  chroma tc = tc0+1 for bS 1..3; 0 otherwise
- strong_o  out  1  bS==4
- filt_en_o  out  1  bS!=0 and alpha!=0 (indexA>=16)
- chroma_o  out  1  chroma_i carried through

Behaviour:
- Reset: all outputs 0, ready_o=1; both stage valid flags cleared. Reset may be asserted mid-stream; in-flight requests are discarded and no output is produced for them.
- Stage 1 (registered on accept):
  - qp_avg = (qp_p+qp_q+1)>>1, computed at QP_W+1 bits.
  - idxA = clip3(0,51, qp_avg+alpha_ofs) and idxB = clip3(0,51, qp_avg+beta_ofs), using signed arithmetic at QP_W+2 bits.
  - bs_i, chroma_i and the clipped indices are registered.
- Stage 2 (output registers):
  - alpha, beta and tc0 come from the db_thresh_rom lookup of stage-1 idxA/idxB/bs.
  - alpha table: indices 0..15 → 0; 16..51 → 4,4,5,6,7,8,9,10,12,13,15,17,20,22,25,28,32,36,40,45,50,56,63,71,80,90,101,113,127,144,162,182,203,226,255,255.
  - beta table: indices 0..15 → 0; 16..51 → 2,2,2,3,3,3,3,4,4,4,6,6,7,7,8,8,9,9,10,10,11,11,12,12,13,13,14,14,15,15,16,16,17,17,18,18.
  - tc0 table: H.264 Table 8-17, rows bS=1,2,3; 0 for idxA<17 (bS=1,2) or idxA<17 (bS=3 column starts at 17 with value 1).
- Latency: 2 cycles from accept to valid_o when there is no stall.
- Handshake:
  - Stage 2 loads when !valid_o | ready_i.
  - Stage 1 loads when !s1_valid | stage-2 load.
  - ready_o = !s1_valid | stage-2 load.
  - Throughput is 1 per cycle under continuous ready_i.
- Stall: while valid_o & !ready_i, all outputs hold stable; at most 2 requests are buffered, after which ready_o=0.
- Simultaneous accept and emit in the same cycle: no bubble and no loss.
- Out-of-range inputs: qp>51 is clipped through clip3; bs values 5..7 are treated as 4.

Decomposition:
- Shared package/defines hold the constants QP_MAX=51 and ALPHA_IDX_MIN=16, and the table widths 8/5/5.
- Sub-module db_thresh_rom: purely combinational case tables for alpha, beta and tc0 (inputs idxA, idxB, bs; outputs alpha, beta, tc0). It is instantiated once in stage 2.

Test Plan:
- qp_p=qp_q=30, ofs=0, bs=2, luma, ready_i=1 -> 2 cycles later: alpha=25, beta=8, tc0=1, tc_c=2, filt_en=1, strong=0.
- qp_p=51, qp_q=50, alpha_ofs=+12, beta_ofs=-12, bs=4 -> idxA=51, idxB=39: alpha=255, beta=12, tc0=0, tc_c=0, strong=1, filt_en=1.
- qp_p=qp_q=10, ofs=0, bs=1 -> alpha=0, beta=0, tc0=0, filt_en=0; also qp=0 with alpha_ofs=-12 -> idxA clipped to 0, alpha=0.
- Stream 5 back-to-back requests with ready_i low for cycles 3..6 -> ready_o drops after 2 buffered; outputs held stable; all 5 results emerge in order with no drop or duplicate.
- Assert rst_n low for 1 cycle while 2 requests are in flight -> valid_o=0 and outputs 0 immediately; ready_o=1 after release; no stale result is emitted.
- bs=0 with qp=40 -> filt_en=0, tc0=0, alpha=80, beta=13 still reported.
